timer_responder: RTL and testbench



---
 rtl/timer_responder_pkg.sv | 23 ++
 rtl/timer_responder_if.sv | 14 +
 rtl/timer_prescaler.sv | 32 +++
 rtl/timer_responder.sv | 107 ++++++++++
 tb/tb_timer_responder.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_responder_pkg.sv
// Shared constants for the memory-mapped timer: register offsets, CTRL bit
// positions and reset values.
package timer_responder_pkg;

  localparam int unsigned OFF_W  = 3;
  localparam int unsigned CTRL_W = 3;

  typedef enum logic [OFF_W-1:0] {
    TMR_CTRL  = 3'd0,
    TMR_PRESC = 3'd1,
    TMR_CMP   = 3'd2,
    TMR_CNT   = 3'd3,
    TMR_STAT  = 3'd4
  } tmr_off_e;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // COMPARE resets to all ones; replicated to the bus width at the use site.
  localparam logic CMP_RST_BIT = 1'b1;

endpackage

// File: rtl/timer_responder_if.sv
// Slave-side memory-map port: shared write data/address, per-slave selects
// and the combinational read-data return.
interface timer_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] address;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] rd;

  modport master (output wd, address, we, re, input rd);
  modport slave  (input wd, address, we, re, output rd);
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: raises tick_c for one cycle every PRESCALE+1 enabled cycles.
module timer_prescaler #(
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic                   en,
  input  logic                   clr,
  output logic                   tick_c
);

  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_c = en && (cnt_q == presc);
    if (clr || !en) begin
      cnt_d = '0;
    end else if (tick_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_responder.sv
// Memory-mapped timer slave: prescaled counter with compare match,
// optional auto-reload, sticky MATCH flag and level interrupt.
module timer_responder
  import timer_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  timer_responder_if.slave   bus,
  output logic               irq
);

  logic [CTRL_W-1:0]      ctrl_q,  ctrl_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [DATA_WIDTH-1:0]  cmp_q,   cmp_d;
  logic [DATA_WIDTH-1:0]  cnt_q,   cnt_d;
  logic                   match_q, match_d;
  logic                   irq_q,   irq_d;
  logic [DATA_WIDTH-1:0]  rd_c;

  logic [OFF_W-1:0] off;
  logic wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_stat;
  logic tick_c, hit_c;
  logic unused_addr;

  assign off         = bus.address[4:2];
  assign unused_addr = ^{bus.address[DATA_WIDTH-1:5], bus.address[1:0]};

  assign wr_ctrl  = bus.we && (off == TMR_CTRL);
  assign wr_presc = bus.we && (off == TMR_PRESC);
  assign wr_cmp   = bus.we && (off == TMR_CMP);
  assign wr_cnt   = bus.we && (off == TMR_CNT);
  assign wr_stat  = bus.we && (off == TMR_STAT);

  timer_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .presc  (presc_q),
    .en     (ctrl_q[CTRL_EN]),
    .clr    (wr_ctrl || wr_presc),
    .tick_c (tick_c)
  );

  // A bus write to COUNT overrides the tick and suppresses that cycle's match.
  assign hit_c = tick_c && !wr_cnt && (cnt_q == cmp_q);

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    match_d = match_q;

    if (tick_c) begin
      cnt_d = (hit_c && ctrl_q[CTRL_AUTO]) ? '0 : cnt_q + DATA_WIDTH'(1);
    end
    if (wr_cnt)   cnt_d   = bus.wd;
    if (wr_ctrl)  ctrl_d  = bus.wd[CTRL_W-1:0];
    if (wr_presc) presc_d = bus.wd[PRESC_WIDTH-1:0];
    if (wr_cmp)   cmp_d   = bus.wd;

    // W1C first so a same-cycle match set wins.
    if (wr_stat && bus.wd[0]) match_d = 1'b0;
    if (hit_c)                match_d = 1'b1;

    irq_d = match_d && ctrl_d[CTRL_IRQ_EN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      cmp_q   <= {DATA_WIDTH{CMP_RST_BIT}};
      cnt_q   <= '0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      irq_q   <= irq_d;
    end
  end

  // Read data is combinational from registered state so MEM/WB captures it this cycle.
  always_comb begin
    rd_c = '0;
    if (bus.re) begin
      case (tmr_off_e'(off))
        TMR_CTRL:  rd_c = DATA_WIDTH'(ctrl_q);
        TMR_PRESC: rd_c = DATA_WIDTH'(presc_q);
        TMR_CMP:   rd_c = cmp_q;
        TMR_CNT:   rd_c = cnt_q;
        TMR_STAT:  rd_c = DATA_WIDTH'(match_q);
        default:   rd_c = '0;
      endcase
    end
  end

  assign bus.rd = rd_c;
  assign irq    = irq_q;

endmodule

// File: tb/tb_timer_responder.sv
// Self-checking bench for timer_responder: directed scenarios plus a
// randomized register-access run checked against a cycle-level model.
module tb_timer_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic irq;

  always #5 clk = ~clk;

  timer_responder_if #(.DATA_WIDTH(32)) bus ();

  timer_responder #(.DATA_WIDTH(32), .PRESC_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .irq   (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model of the peripheral.
  logic [2:0]  m_ctrl;
  logic [15:0] m_presc;
  logic [31:0] m_cmp;
  logic [31:0] m_cnt;
  logic        m_match;
  int unsigned m_elapsed;  // enabled cycles since the prescaler last restarted

  task automatic model_reset();
    m_ctrl = 3'd0; m_presc = 16'd0; m_cmp = 32'hFFFF_FFFF;
    m_cnt = 32'd0; m_match = 1'b0; m_elapsed = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return {16'd0, m_presc};
      3'd2:    return m_cmp;
      3'd3:    return m_cnt;
      3'd4:    return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return m_match & m_ctrl[2];
  endfunction

  // One clock edge of the model: every (PRESCALE+1)-th enabled cycle is a tick.
  task automatic model_edge(input logic w, input logic [2:0] off, input logic [31:0] data);
    logic tick, wcnt, hit;
    logic [31:0] n_cnt;
    tick  = m_ctrl[0] && ((m_elapsed % (32'(m_presc) + 32'd1)) == 32'(m_presc));
    wcnt  = w && (off == 3'd3);
    hit   = tick && !wcnt && (m_cnt == m_cmp);
    n_cnt = m_cnt;
    if (wcnt)      n_cnt = data;
    else if (tick) n_cnt = (hit && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
    m_match = hit || (m_match && !(w && off == 3'd4 && data[0]));
    if (w && (off == 3'd0 || off == 3'd1)) m_elapsed = 0;
    else if (m_ctrl[0])                    m_elapsed = m_elapsed + 1;
    else                                   m_elapsed = 0;
    m_cnt = n_cnt;
    if (w && off == 3'd0) m_ctrl  = data[2:0];
    if (w && off == 3'd1) m_presc = data[15:0];
    if (w && off == 3'd2) m_cmp   = data;
  endtask

  // Drive one bus cycle (write or idle) across a clock edge, stepping the model.
  task automatic step(input logic w, input logic [2:0] off, input logic [31:0] data);
    logic [31:0] r;
    r = $urandom;
    bus.we      = w;
    bus.address = {r[31:5], off, r[1:0]};
    bus.wd      = data;
    @(posedge clk);
    model_edge(w, off, data);
    #1;
    bus.we = 1'b0;
    bus.wd = 32'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0);
  endtask

  task automatic read_reg(input logic [2:0] off, output logic [31:0] v);
    logic [31:0] r;
    r = $urandom;
    bus.re      = 1'b1;
    bus.address = {r[31:5], off, r[1:0]};
    #1;
    v = bus.rd;
    bus.re = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_v [8];
    exp_v = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    rst_n = 1'b0;
    bus.we = 1'b0; bus.re = 1'b0; bus.wd = 32'd0; bus.address = 32'd0;
    #12;
    n_tests++;
    if (irq !== 1'b0 || bus.rd !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: irq=%b rd=%h expected irq=0 rd=0", irq, bus.rd);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_tests++;
      if (v !== exp_v[i]) begin
        n_fail++;
        $display("FAIL reset_read off=%0d: got %h expected %h", i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    step(1'b1, 3'd1, 32'd3);
    step(1'b1, 3'd2, 32'd5);
    step(1'b1, 3'd0, 32'b101);
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, 3'd0, 32'd0);
      read_reg(3'd3, v);
      n_tests++;
      if (v !== m_cnt || irq !== m_irq()) begin
        n_fail++;
        $display("FAIL oneshot_cycle %0d: cnt=%h irq=%b expected cnt=%h irq=%b", i, v, irq, m_cnt, m_irq());
      end
      if (i == 23) begin
        n_tests++;
        if (v !== 32'd5 || irq !== 1'b0) begin
          n_fail++;
          $display("FAIL oneshot_before_match: cnt=%h irq=%b expected cnt=5 irq=0", v, irq);
        end
      end
      if (i == 24) begin
        n_tests++;
        if (v !== 32'd6 || irq !== 1'b1) begin
          n_fail++;
          $display("FAIL oneshot_match: cnt=%h irq=%b expected cnt=6 irq=1", v, irq);
        end
      end
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    do_reset();
    step(1'b1, 3'd1, 32'd3);
    step(1'b1, 3'd2, 32'd5);
    step(1'b1, 3'd0, 32'b111);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 3'd0, 32'd0);
      read_reg(3'd3, v);
      n_tests++;
      if (v !== m_cnt || v > 32'd5) begin
        n_fail++;
        $display("FAIL autoreload_cnt cycle %0d: got %h expected %h (<=5)", i, v, m_cnt);
      end
    end
    read_reg(3'd4, v);
    n_tests++;
    if (v !== 32'd1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL autoreload_sticky: stat=%h irq=%b expected stat=1 irq=1", v, irq);
    end
    step(1'b1, 3'd0, 32'b110);
    step(1'b1, 3'd4, 32'd0);
    n_tests++;
    if (irq !== 1'b1 || irq !== m_irq()) begin
      n_fail++;
      $display("FAIL w0_no_effect: irq=%b expected 1", irq);
    end
    step(1'b1, 3'd4, 32'd1);
    read_reg(3'd4, v);
    n_tests++;
    if (irq !== 1'b0 || v !== 32'd0) begin
      n_fail++;
      $display("FAIL w1c_clear: irq=%b stat=%h expected irq=0 stat=0", irq, v);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v, s;
    do_reset();
    step(1'b1, 3'd3, 32'hFFFF_FFFE);
    step(1'b1, 3'd2, 32'h10);
    step(1'b1, 3'd0, 32'd1);
    step(1'b0, 3'd0, 32'd0);
    read_reg(3'd3, v);
    n_tests++;
    if (v !== 32'hFFFF_FFFF || v !== m_cnt) begin
      n_fail++;
      $display("FAIL wrap_top: got %h expected ffffffff", v);
    end
    step(1'b0, 3'd0, 32'd0);
    read_reg(3'd3, v);
    read_reg(3'd4, s);
    n_tests++;
    if (v !== 32'd0 || s !== 32'd0 || v !== m_cnt) begin
      n_fail++;
      $display("FAIL wrap_zero: cnt=%h stat=%h expected cnt=0 stat=0", v, s);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    do_reset();
    step(1'b1, 3'd1, 32'd3);
    step(1'b1, 3'd0, 32'd1);
    idle(3);
    step(1'b1, 3'd3, 32'h100);
    read_reg(3'd3, v);
    n_tests++;
    if (v !== 32'h100 || v !== m_cnt) begin
      n_fail++;
      $display("FAIL count_write_vs_tick: got %h expected 00000100", v);
    end
    step(1'b1, 3'd2, 32'h101);
    idle(6);
    step(1'b1, 3'd4, 32'd1);
    read_reg(3'd4, v);
    n_tests++;
    if (v !== 32'd1 || v !== {31'd0, m_match}) begin
      n_fail++;
      $display("FAIL w1c_vs_match: stat=%h expected 1", v);
    end
    read_reg(3'd3, v);
    n_tests++;
    if (v !== 32'h102 || v !== m_cnt) begin
      n_fail++;
      $display("FAIL count_after_match: got %h expected 00000102", v);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] c, s;
    do_reset();
    step(1'b1, 3'd2, 32'd0);
    step(1'b1, 3'd0, 32'b101);
    idle(3);
    read_reg(3'd3, c);
    n_tests++;
    if (c !== 32'd3 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: cnt=%h irq=%b expected cnt=3 irq=1", c, irq);
    end
    rst_n = 1'b0;
    #1;
    read_reg(3'd3, c);
    read_reg(3'd4, s);
    n_tests++;
    if (c !== 32'd0 || s !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: cnt=%h stat=%h irq=%b expected all 0", c, s, irq);
    end
    rst_n = 1'b1;
    model_reset();
    idle(8);
    read_reg(3'd3, c);
    read_reg(3'd0, s);
    n_tests++;
    if (c !== 32'd0 || s !== 32'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: cnt=%h ctrl=%h expected 0", c, s);
    end
  endtask

  task automatic test_random();
    logic [31:0] v, r, d;
    logic [2:0]  off, roff;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r   = $urandom;
      off = 3'($urandom_range(0, 7));
      case (off)
        3'd1:    d = {r[31:16], 14'd0, r[1:0]};
        3'd2:    d = 32'($urandom_range(0, 12));
        3'd3:    d = (r[7:0] < 8'd20) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 12));
        default: d = r;
      endcase
      step($urandom_range(0, 9) < 3, off, d);
      read_reg(3'd3, v);
      n_tests++;
      if (v !== m_cnt || irq !== m_irq()) begin
        n_fail++;
        $display("FAIL random_cnt cycle %0d: cnt=%h irq=%b expected cnt=%h irq=%b", i, v, irq, m_cnt, m_irq());
      end
      roff = 3'($urandom_range(0, 7));
      read_reg(roff, v);
      n_tests++;
      if (v !== m_read(roff)) begin
        n_fail++;
        $display("FAIL random_read cycle %0d off=%0d: got %h expected %h", i, roff, v, m_read(roff));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_wrap();
    test_collision();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
